// File: rtl/wash_pkg.sv
// Shared state codes, mode codes, output bundle and decode helpers for the wash cycle controller.
package wash_pkg;

   localparam int unsigned WDOG_CYCLES_DEF = 2047;
   localparam int unsigned WDOG_W_DEF      = 11;
   localparam int unsigned PHASE_W         = 3;
   localparam int unsigned MODE_W          = 2;

   localparam logic [PHASE_W-1:0] ST_IDLE  = 3'd0;
   localparam logic [PHASE_W-1:0] ST_READY = 3'd1;
   localparam logic [PHASE_W-1:0] ST_SOAK  = 3'd2;
   localparam logic [PHASE_W-1:0] ST_WASH  = 3'd3;
   localparam logic [PHASE_W-1:0] ST_RINSE = 3'd4;
   localparam logic [PHASE_W-1:0] ST_SPIN  = 3'd5;
   localparam logic [PHASE_W-1:0] ST_DONE  = 3'd6;
   localparam logic [PHASE_W-1:0] ST_FAULT = 3'd7;

   localparam logic [MODE_W-1:0] MODE_1 = 2'd1;
   localparam logic [MODE_W-1:0] MODE_2 = 2'd2;
   localparam logic [MODE_W-1:0] MODE_3 = 2'd3;

   typedef enum logic [PHASE_W-1:0] {
      S_IDLE  = ST_IDLE,
      S_READY = ST_READY,
      S_SOAK  = ST_SOAK,
      S_WASH  = ST_WASH,
      S_RINSE = ST_RINSE,
      S_SPIN  = ST_SPIN,
      S_DONE  = ST_DONE,
      S_FAULT = ST_FAULT
   } state_t;

   typedef struct packed {
      logic idle;
      logic ready1;
      logic ready2;
      logic ready3;
      logic soak;
      logic wash;
      logic rinse;
      logic spin;
      logic done;
      logic fault;
   } outs_t;

   localparam outs_t IDLE_OUTS = '{idle: 1'b1, default: 1'b0};

   // Phase step: abort wins, then pause hold, then the phase's own done flag, then watchdog expiry.
   function automatic state_t phase_next(state_t cur, state_t adv, logic abort,
                                         logic hold, logic flag, logic expired);
      state_t nxt;
      nxt = cur;
      if (abort)        nxt = S_IDLE;
      else if (hold)    nxt = cur;
      else if (flag)    nxt = adv;
      else if (expired) nxt = S_FAULT;
      return nxt;
   endfunction

   function automatic outs_t decode(state_t s, logic [MODE_W-1:0] mode, logic hold);
      outs_t o;
      o = '0;
      case (s)
         S_IDLE:  o.idle = 1'b1;
         S_READY: begin
            o.ready1 = (mode == MODE_1);
            o.ready2 = (mode == MODE_2);
            o.ready3 = (mode == MODE_3);
         end
         S_SOAK:  o.soak  = ~hold;
         S_WASH:  o.wash  = ~hold;
         S_RINSE: o.rinse = ~hold;
         S_SPIN:  o.spin  = ~hold;
         S_DONE:  o.done  = 1'b1;
         S_FAULT: begin
            o.idle  = 1'b1;
            o.fault = 1'b1;
         end
         default: o.idle = 1'b1;
      endcase
      return o;
   endfunction

endpackage

// File: rtl/phase_watchdog.sv
// Per-phase cycle counter; expired_c rises once the current phase has lasted LIMIT cycles.
module phase_watchdog #(
   parameter int unsigned LIMIT = 2047,
   parameter int unsigned W     = 11
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expired_c
);

   logic [W-1:0] cnt;

   // cnt holds completed cycles in the phase; the current cycle makes it cnt+1.
   assign expired_c = (32'(cnt) + 32'd1) >= LIMIT;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                    cnt <= '0;
      else if (clr)               cnt <= '0;
      else if (en && !expired_c)  cnt <= cnt + W'(1);
   end

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing machine cycle sequencer: select, soak, wash, rinse, spin, done, with per-phase watchdog.
// Optional lid-open pause in the timed phases when WASH_LID_PAUSE_EN is defined.
module wash_cycle_ctrl
   import wash_pkg::*;
#(
   parameter int unsigned WDOG_CYCLES = WDOG_CYCLES_DEF,
   parameter int unsigned WDOG_W      = WDOG_W_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic               abort,
   input  logic [MODE_W-1:0]  mode,
   input  logic               lid_closed,
   input  logic               soaked,
   input  logic               washed,
   input  logic               rinsed,
   input  logic               spun,
   output logic               idle,
   output logic               ready1,
   output logic               ready2,
   output logic               ready3,
   output logic               soak,
   output logic               wash,
   output logic               rinse,
   output logic               spin,
   output logic               done,
   output logic               fault,
   output logic               paused,
   output logic [PHASE_W-1:0] phase_code
);

   state_t state, state_next;
   outs_t  outs_q;
   logic   in_phase_c, pause_c, paused_next_c;
   logic   wd_clr_c, wd_en_c, wd_expired_c;

   assign in_phase_c = state inside {S_SOAK, S_WASH, S_RINSE, S_SPIN};

`ifdef WASH_LID_PAUSE_EN
   assign pause_c = in_phase_c && !lid_closed;
`else
   assign pause_c = 1'b0;
`endif

   assign wd_clr_c = (state_next != state);
   assign wd_en_c  = in_phase_c && !pause_c;

   phase_watchdog #(
      .LIMIT (WDOG_CYCLES),
      .W     (WDOG_W)
   ) u_wdog (
      .clk       (clk),
      .rst       (rst),
      .clr       (wd_clr_c),
      .en        (wd_en_c),
      .expired_c (wd_expired_c)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_comb begin
      state_next    = state;
      paused_next_c = 1'b0;
      case (state)
         S_IDLE:  if (start && lid_closed && (mode != '0)) state_next = S_READY;
         S_READY: state_next = abort ? S_IDLE : S_SOAK;
         S_SOAK:  state_next = phase_next(state, S_WASH,  abort, pause_c, soaked, wd_expired_c);
         S_WASH:  state_next = phase_next(state, S_RINSE, abort, pause_c, washed, wd_expired_c);
         S_RINSE: state_next = phase_next(state, S_SPIN,  abort, pause_c, rinsed, wd_expired_c);
         S_SPIN:  state_next = phase_next(state, S_DONE,  abort, pause_c, spun,   wd_expired_c);
         S_DONE:  state_next = S_IDLE;
         S_FAULT: if (abort) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
      paused_next_c = pause_c && (state_next == state);
   end

   // Output registers track the state being entered so they line up with the state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         outs_q     <= IDLE_OUTS;
         paused     <= 1'b0;
         phase_code <= ST_IDLE;
      end else begin
         outs_q     <= decode(state_next, mode, paused_next_c);
         paused     <= paused_next_c;
         phase_code <= state_next;
      end
   end

   assign idle   = outs_q.idle;
   assign ready1 = outs_q.ready1;
   assign ready2 = outs_q.ready2;
   assign ready3 = outs_q.ready3;
   assign soak   = outs_q.soak;
   assign wash   = outs_q.wash;
   assign rinse  = outs_q.rinse;
   assign spin   = outs_q.spin;
   assign done   = outs_q.done;
   assign fault  = outs_q.fault;

endmodule

// File: doc/wash_cycle_ctrl.md
Name: wash_cycle_ctrl

Overview:
- Sequencing controller for the automatic washing machine.
- Drives the phase-enable lines (idle, ready1-3, soak, wash, rinse, spin) into the phase timer and consumes its sticky done flags (soaked, washed, rinsed, spun).
- Walks one full cycle per accepted start: select, soak, wash, rinse, spin, done.
- A per-phase watchdog traps a stuck timer into a FAULT state.

Parameters:
- WDOG_CYCLES, 2047, max cycles allowed in any one phase before FAULT. Must be >= 1001 (the longest timer phase plus margin).
- WDOG_W, 11, watchdog counter width. Must hold WDOG_CYCLES.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  request a cycle; level-sampled in IDLE
- abort  input  1  cancel the current cycle / clear FAULT
- mode  input  2  program select: 1, 2 or 3 (maps to ready1/2/3); 0 is invalid
- lid_closed  input  1  lid interlock, 1 = closed
- soaked, washed, rinsed, spun  input  1 each  sticky done flags from the timer
- idle  output  1  timer clear / machine idle
- ready1, ready2, ready3  output  1 each  one-cycle wash-time select pulse
- soak, wash, rinse, spin  output  1 each  phase enables to the timer
- done  output  1  one-cycle pulse when a cycle completes
- fault  output  1  watchdog expired; held until abort
- paused  output  1  lid-open pause (0 unless LID_PAUSE_EN)
- phase_code  output  3  current state code, for the display

Behaviour:
- All outputs are registered Moore decodes of the state; no combinational input-to-output paths.
- States and codes: IDLE=0, READY=1, SOAK=2, WASH=3, RINSE=4, SPIN=5, DONE=6, FAULT=7.
- Reset (async, any time, including mid-phase):
  - state = IDLE, idle = 1, all other outputs 0, watchdog = 0.
  - Effect takes hold immediately, not at the next edge.
- IDLE:
  - Leaves only when start=1 and lid_closed=1 and mode is 1, 2 or 3; goes to READY.
  - Otherwise stays. start with mode=0 is ignored.
- READY:
  - Lasts exactly one cycle.
  - Asserts exactly one of ready1/2/3 per the mode value captured on the accepting edge. mode changes after acceptance are ignored.
  - idle = 0. Next state is SOAK.
  - Latency: start sampled at edge N; readyX high after N+1; soak high after N+2.
- SOAK/WASH/RINSE/SPIN:
  - The matching enable is high; all other enables are low.
  - Advances on the first edge that samples its own flag high: soaked moves to WASH, washed to RINSE, rinsed to SPIN, spun to DONE.
  - Flags belonging to other phases are ignored; soaked stays high throughout WASH by design.
- DONE: done = 1 for one cycle, then IDLE (idle = 1 next).
- Watchdog:
  - Clears on entry to each phase and increments each cycle in the phase.
  - Reaching WDOG_CYCLES goes to FAULT.
- FAULT: all enables low, idle = 1, fault = 1. Leaves to IDLE only on abort = 1.
- Abort:
  - In READY through SPIN, abort = 1 goes to IDLE next cycle.
  - Abort in IDLE or DONE has no effect; DONE still completes.
- start while not in IDLE: ignored. A held start re-triggers a new cycle from IDLE; this is intentional.
- Simultaneous events, in priority order:
  - rst beats everything.
  - abort beats a done flag.
  - A done flag beats watchdog expiry; the phase advances and there is no FAULT.
- The watchdog does not wrap: the compare is >= WDOG_CYCLES.

Optional Feature:
- Macro: WASH_LID_PAUSE_EN.
- Defined:
  - lid_closed = 0 in SOAK..SPIN sets paused = 1 and drops the phase enable, so timer counters hold.
  - State and watchdog are frozen.
  - lid_closed = 1 resumes the same phase next cycle.
  - abort during the pause goes to IDLE.
- Undefined:
  - lid_closed is checked only at start, and paused is tied to 0.

Decomposition:
- Package wash_pkg holds:
  - state/phase_code localparams (0..7)
  - mode codes (MODE_1/2/3 = 1/2/3)
  - WDOG default
- Sub-module phase_watchdog: counter with clr, en and expired.
  - en low when paused or outside a phase.
  - clr on phase entry.
- The FSM and output decode remain in wash_cycle_ctrl.

Test Plan:
- Full cycle, mode=2, paired with the timer model:
  - ready2 pulses one cycle.
  - soak lasts ~801 cycles, wash ~751, rinse ~901, spin ~1001.
  - done pulses once, then idle = 1.
  - phase_code sequence is 0,1,2,3,4,5,6,0.
- start with mode=0 or lid_closed=0: state stays IDLE, idle = 1, no ready pulse.
- Stuck timer (spun forced 0): FAULT after exactly 2047 cycles in SPIN, fault = 1, enables low. Abort returns to IDLE.
- Abort in WASH at cycle 300: idle = 1 next cycle, wash = 0, no done. Same-cycle abort and washed also ends in IDLE.
- rst pulse mid-RINSE between edges: outputs show idle=1, rinse=0 immediately. After rst drops, a new start begins a cycle.
- WASH_LID_PAUSE_EN defined, lid opened for 100 cycles in WASH:
  - paused = 1 and wash = 0 for those cycles.
  - watchdog frozen.
  - wash total on-time is unchanged at ~751 cycles for mode 2.
